inst_encoder: RTL
=================

// Module: inst_encoder
// PURPOSE
//  Packs RV32I instruction fields (opcode, rd, rs1, rs2, fn3, fn7, imm) into 32-bit instruction words.
//  Encoded words are buffered in a DEPTH-entry FIFO and streamed out over valid/ready, each with a word address.
//  Sits between the test-program/boot sequencer and instruction-memory write port; inverse of the field decoder.
// PARAMETERS
//  DEPTH      4   FIFO entries; power of 2, >=2
//  ADDR_W     10  width of instAddr (word address)
//  BASE_ADDR  0   instAddr value after reset/flush
// PORTS
//  clk       in   1               clock, all state on rising edge
//  rst       in   1               asynchronous, active-high reset
//  flush     in   1               sync clear of FIFO + address counter
//  inValid   in   1               field bundle valid
//  inReady   out  1               encoder can accept (FIFO not full)
//  opcode    in   7               instruction opcode
//  rd/rs1/rs2 in  5 each          register indices
//  fn3       in   3               funct3
//  fn7       in   7               funct7 (R-type; OP-IMM shifts)
//  imm       in   32              sign-extended immediate (byte offset for B/J)
//  outValid  out  1               instOut/instAddr valid
//  outReady  in   1               memory side accepts word
//  instOut   out  32              encoded instruction at FIFO head
//  instAddr  out  ADDR_W          word address for instOut
//  count     out  $clog2(DEPTH)+1 FIFO occupancy
//  illegal   out  1               1-cycle pulse, unsupported opcode (ENC_ILLEGAL_CHECK_EN only)
// BEHAVIOUR
//  Encoding, combinational at input, written into FIFO on push:
//   0110111/0010111 U: {imm[31:12],rd,op}
//   1101111 J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//   1100111/0000011/0010011 I: {imm[11:0],rs1,fn3,rd,op}
//   0010011 with fn3=001/101: {fn7,imm[4:0],rs1,fn3,rd,op}
//   0100011 S: {imm[11:5],rs2,rs1,fn3,imm[4:0],op}
//   1100011 B: {imm[12],imm[10:5],rs2,rs1,fn3,imm[4:1],imm[11],op}
//   0110011 R: {fn7,rs2,rs1,fn3,rd,op}
//   Unused imm bits are ignored; no range check.
//  Push = inValid&inReady; inReady = (count<DEPTH); inReady independent of outReady.
//  Pop = outValid&outReady; outValid = (count!=0).
//  instOut = head entry, 32'h0 when empty.
//  Latency: word pushed at edge N is on instOut with outValid=1 after edge N (first-word fall-through).
//  Push+pop same cycle (not full, not empty): count unchanged, order preserved.
//  Full: push blocked even if outReady=1 that cycle.
//  instAddr: register, +1 on each pop, wraps 2^ADDR_W-1 -> 0.
//  flush: count->0, pointers->0, instAddr->BASE_ADDR at next edge; overrides push/pop that cycle; pushed word discarded.
//  rst (any time, incl. mid-stream): count=0, pointers=0, outValid=0, instOut=0, instAddr=BASE_ADDR, illegal=0, inReady=1 after release.
// CONFIGURATION
//  ENC_ILLEGAL_CHECK_EN defined: opcode outside list above -> inReady still 1, handshake completes, nothing pushed;
//   illegal=1 for exactly the cycle after the handshake.
//  Undefined: unsupported opcode encodes as NOP 32'h00000013 and is pushed; illegal tied 0.
// TESTING
//  R: op=0110011 rd=3 rs1=1 rs2=2 fn3=0 fn7=0 -> instOut=32'h002081B3, instAddr=0
//  S: op=0100011 rs1=2 rs2=5 fn3=010 imm=8 -> 32'h00512423; B: op=1100011 rs1=1 rs2=2 fn3=0 imm=-4 -> 32'hFE208EE3
//  Full: outReady=0, push 5 -> 4 accepted, inReady=0, count=4; outReady=1 -> same 4 words in order, addr 0..3
//  Wrap/flush: ADDR_W=2, 5 pops -> instAddr 0,1,2,3,0; flush with count=3 -> count=0, outValid=0, instAddr=0 next cycle
//  Reset mid-stream: rst with count=2 -> outValid=0, count=0 immediately (async), instAddr=BASE_ADDR
//  Macro: op=7'b1111111 -> EN: illegal 1-cycle pulse, count unchanged; not EN: 32'h00000013 pushed

Source files
------------

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//   Packs RV32I instruction fields into 32-bit instruction words, buffers them
//   in a DEPTH-entry first-word-fall-through FIFO and streams them out over a
//   valid/ready handshake together with a sequential word address.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous clear of FIFO and address counter
//   inValid / inReady   field-bundle handshake (inReady = FIFO not full)
//   opcode..imm         instruction fields; imm is sign-extended, byte offset
//                       for branch/jump targets
//   outValid / outReady encoded-word handshake
//   instOut             encoded word at FIFO head (0 when empty)
//   instAddr            word address of instOut, +1 per pop, wraps
//   count               FIFO occupancy
//   illegal             1-cycle pulse after an unsupported opcode handshake
//
// Configuration macro
//   ENC_ILLEGAL_CHECK_EN  defined  : unsupported opcodes are consumed but not
//                                    pushed, and illegal pulses.
//                         undefined: unsupported opcodes encode as NOP
//                                    (32'h00000013); illegal is tied low.
// -----------------------------------------------------------------------------
module inst_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [6:0]               opcode,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [2:0]               fn3,
  input  logic [6:0]               fn7,
  input  logic [31:0]              imm,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [31:0]              instOut,
  output logic [ADDR_W-1:0]        instAddr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     illegal
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_RESET = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       NOP_WORD   = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_REG    = 7'b0110011
  } opcode_e;

  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [31:0]       enc_word;
  logic              accept;
  logic              do_write;
  logic              do_pop;

`ifdef ENC_ILLEGAL_CHECK_EN
  logic op_legal;
  logic illegal_q, illegal_d;
`endif

  // Field packing. Anything not in the supported opcode list falls through to
  // the NOP default.
  // NOTE: every signal written in an always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    enc_word = NOP_WORD;
`ifdef ENC_ILLEGAL_CHECK_EN
    op_legal = 1'b1;
`endif
    case (opcode)
      OP_LUI, OP_AUIPC:  enc_word = {imm[31:12], rd, opcode};
      OP_JAL:            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      OP_JALR, OP_LOAD:  enc_word = {imm[11:0], rs1, fn3, rd, opcode};
      OP_IMM: begin
        // SLLI/SRLI/SRAI carry funct7 in the upper immediate bits.
        if (fn3 == 3'b001 || fn3 == 3'b101)
          enc_word = {fn7, imm[4:0], rs1, fn3, rd, opcode};
        else
          enc_word = {imm[11:0], rs1, fn3, rd, opcode};
      end
      OP_STORE:          enc_word = {imm[11:5], rs2, rs1, fn3, imm[4:0], opcode};
      OP_BRANCH:         enc_word = {imm[12], imm[10:5], rs2, rs1, fn3, imm[4:1], imm[11], opcode};
      OP_REG:            enc_word = {fn7, rs2, rs1, fn3, rd, opcode};
      default: begin
`ifdef ENC_ILLEGAL_CHECK_EN
        op_legal = 1'b0;
`endif
      end
    endcase
  end

  assign inReady  = (count_q < FULL_CNT);
  assign outValid = (count_q != '0);
  assign instOut  = outValid ? mem_q[rd_ptr_q] : 32'h0;
  assign instAddr = addr_q;
  assign count    = count_q;

  // flush wins over both handshakes: nothing is written or popped that cycle.
  assign accept = inValid & inReady & ~flush;
  assign do_pop = outValid & outReady & ~flush;
`ifdef ENC_ILLEGAL_CHECK_EN
  assign do_write  = accept & op_legal;
  assign illegal_d = accept & ~op_legal;
  assign illegal   = illegal_q;
`else
  assign do_write  = accept;
  assign illegal   = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = ADDR_RESET;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        addr_d   = addr_q + 1'b1;
      end
      case ({do_write, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= ADDR_RESET;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
    end
  end

`ifdef ENC_ILLEGAL_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
`endif

  // NOTE: the storage array has no reset; entries are only observed when
  // count marks them valid, and instOut is forced to 0 when empty.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= enc_word;
  end

endmodule
